// File: rtl/pipe_reg_pkg.sv
// Shared types and width constants for the elastic pipeline stage registers.
package pipe_reg_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_t;

    localparam int unsigned STATS_W = 32;

    // Default payload/control widths for each stage boundary.
    localparam int unsigned IFID_DATA_W  = 64;
    localparam int unsigned IFID_CTRL_W  = 16;
    localparam int unsigned IDEX_DATA_W  = 64;
    localparam int unsigned IDEX_CTRL_W  = 16;
    localparam int unsigned EXMEM_DATA_W = 64;
    localparam int unsigned EXMEM_CTRL_W = 16;
    localparam int unsigned MEMWB_DATA_W = 64;
    localparam int unsigned MEMWB_CTRL_W = 16;

    function automatic logic [1:0] occ_of(input pipe_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            PS_ONE:  occ = 2'd1;
            PS_TWO:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_sat_ctr.sv
// Saturating event counter for stage statistics; only built with PIPE_SKID_REG_STATS_EN.
`ifdef PIPE_SKID_REG_STATS_EN
module pipe_sat_ctr #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with a 2-entry skid buffer and registered in_ready.
// Optional statistics counters are enabled by defining PIPE_SKID_REG_STATS_EN.
module pipe_skid_reg
    import pipe_reg_pkg::*;
#(
    parameter int unsigned            DATA_W      = 64,
    parameter int unsigned            CTRL_W      = 16,
    parameter logic [CTRL_W-1:0]      CTRL_BUBBLE = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       bubble_cycles
);

    pipe_state_t       state, state_n;
    logic [DATA_W-1:0] main_data_n, skid_data, skid_data_n;
    logic [CTRL_W-1:0] main_ctrl_n, skid_ctrl, skid_ctrl_n;
    logic              in_fire, out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= PS_EMPTY;
            out_data  <= '0;
            out_ctrl  <= CTRL_BUBBLE;
            skid_data <= '0;
            skid_ctrl <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
        end else begin
            state     <= state_n;
            out_data  <= main_data_n;
            out_ctrl  <= main_ctrl_n;
            skid_data <= skid_data_n;
            skid_ctrl <= skid_ctrl_n;
            // Status outputs are precomputed from the next state so they come straight from flops.
            out_valid <= (state_n != PS_EMPTY);
            in_ready  <= (state_n != PS_TWO);
            occupancy <= occ_of(state_n);
        end
    end

    always_comb begin
        state_n     = state;
        main_data_n = out_data;
        main_ctrl_n = out_ctrl;
        skid_data_n = skid_data;
        skid_ctrl_n = skid_ctrl;

        unique case (state)
            PS_EMPTY: begin
                if (in_fire) begin
                    main_data_n = in_data;
                    main_ctrl_n = in_ctrl;
                    state_n     = PS_ONE;
                end
            end
            PS_ONE: begin
                if (in_fire && out_fire) begin
                    main_data_n = in_data;
                    main_ctrl_n = in_ctrl;
                end else if (out_fire) begin
                    main_data_n = '0;
                    main_ctrl_n = CTRL_BUBBLE;
                    state_n     = PS_EMPTY;
                end else if (in_fire) begin
                    skid_data_n = in_data;
                    skid_ctrl_n = in_ctrl;
                    state_n     = PS_TWO;
                end
            end
            PS_TWO: begin
                if (out_fire) begin
                    main_data_n = skid_data;
                    main_ctrl_n = skid_ctrl;
                    skid_data_n = '0;
                    skid_ctrl_n = '0;
                    state_n     = PS_ONE;
                end
            end
            default: begin
                main_data_n = '0;
                main_ctrl_n = CTRL_BUBBLE;
                state_n     = PS_EMPTY;
            end
        endcase

        if (flush) begin
            state_n     = PS_EMPTY;
            main_data_n = '0;
            main_ctrl_n = CTRL_BUBBLE;
            skid_data_n = '0;
            skid_ctrl_n = '0;
        end
    end

`ifdef PIPE_SKID_REG_STATS_EN
    logic stall_inc, bubble_inc;

    assign stall_inc  = out_valid & ~out_ready;
    assign bubble_inc = ~out_valid & ~flush;

    pipe_sat_ctr #(.WIDTH(STATS_W)) u_stall_ctr (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    pipe_sat_ctr #(.WIDTH(STATS_W)) u_bubble_ctr (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (bubble_inc),
        .count (bubble_cycles)
    );
`else
    assign stall_cycles  = '0;
    assign bubble_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed table-driven bench for pipe_skid_reg, plus reset, async-reset and stats sequences.
module tb_pipe_skid_reg;

    localparam int unsigned    DW  = 64;
    localparam int unsigned    CW  = 16;
    localparam logic [CW-1:0]  BUB = 16'hB0B0;

`ifdef PIPE_SKID_REG_STATS_EN
    localparam logic [31:0] EXP_STALL  = 32'd5;
    localparam logic [31:0] EXP_BUBBLE = 32'd4;
`else
    localparam logic [31:0] EXP_STALL  = 32'd0;
    localparam logic [31:0] EXP_BUBBLE = 32'd0;
`endif

    logic          CLK;
    logic          nRST;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;
    logic [31:0]   stall_cycles;
    logic [31:0]   bubble_cycles;

    int n_vec = 0;
    int n_err = 0;

    pipe_skid_reg #(
        .DATA_W      (DW),
        .CTRL_W      (CW),
        .CTRL_BUBBLE (BUB)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_ctrl       (in_ctrl),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_ctrl      (out_ctrl),
        .occupancy     (occupancy),
        .stall_cycles  (stall_cycles),
        .bubble_cycles (bubble_cycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          fl;
        logic          ov;
        logic [DW-1:0] od;
        logic          ir;
        logic [1:0]    occ;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [CW-1:0] mkc(input logic [DW-1:0] d);
        return {8'hC3, d[7:0]};
    endfunction

    task automatic add(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl,
                       input logic ov, input logic [DW-1:0] od, input logic ir, input logic [1:0] occ);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.od = od; v.ir = ir; v.occ = occ;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = mkc(d);
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
        drive(iv, d, ordy, fl);
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, ".in_ready"},  {63'd0, in_ready},  64'd1);
        chk({tag, ".out_ctrl"},  {48'd0, out_ctrl},  {48'd0, BUB});
        chk({tag, ".out_data"},  out_data,           64'd0);
        chk({tag, ".occupancy"}, {62'd0, occupancy}, 64'd0);
    endtask

    initial begin
        // Streaming, 1-cycle latency, occupancy 1 throughout.
        add(1, 64'h1, 1, 0,  1, 64'h1, 1, 1);
        add(1, 64'h2, 1, 0,  1, 64'h2, 1, 1);
        add(1, 64'h3, 1, 0,  1, 64'h3, 1, 1);
        add(1, 64'h4, 1, 0,  1, 64'h4, 1, 1);
        add(1, 64'hDEAD_BEEF_0123_4505, 1, 0,  1, 64'hDEAD_BEEF_0123_4505, 1, 1);
        add(1, 64'h6, 1, 0,  1, 64'h6, 1, 1);
        add(1, 64'h7, 1, 0,  1, 64'h7, 1, 1);
        add(1, 64'h8, 1, 0,  1, 64'h8, 1, 1);
        add(0, 64'h0, 1, 0,  0, 64'h0, 1, 0);
        // Back-pressure: A main, B skid, C refused, then drained in order.
        add(1, 64'hA, 0, 0,  1, 64'hA, 1, 1);
        add(1, 64'hB, 0, 0,  1, 64'hA, 0, 2);
        add(1, 64'hC, 0, 0,  1, 64'hA, 0, 2);
        add(1, 64'hC, 1, 0,  1, 64'hB, 1, 1);
        add(1, 64'hC, 1, 0,  1, 64'hC, 1, 1);
        add(0, 64'h0, 0, 0,  1, 64'hC, 1, 1);
        add(0, 64'h0, 1, 0,  0, 64'h0, 1, 0);
        // Flush while full with a new entry offered; that entry must vanish.
        add(1, 64'h1A, 0, 0, 1, 64'h1A, 1, 1);
        add(1, 64'h1B, 0, 0, 1, 64'h1A, 0, 2);
        add(1, 64'hD,  0, 1, 0, 64'h0,  1, 0);
        add(0, 64'h0,  1, 0, 0, 64'h0,  1, 0);
        // Flush in PS_ONE with an accepted in_fire, and flush while empty.
        add(1, 64'hE,  0, 0, 1, 64'hE,  1, 1);
        add(1, 64'hF,  0, 1, 0, 64'h0,  1, 0);
        add(1, 64'h11, 1, 1, 0, 64'h0,  1, 0);
        add(0, 64'h0,  1, 0, 0, 64'h0,  1, 0);

        drive(0, '0, 0, 0);
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk_idle("reset");

        @(posedge CLK);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("vec%0d.out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].ov});
            chk($sformatf("vec%0d.out_data", i), out_data, tbl[i].od);
            chk($sformatf("vec%0d.out_ctrl", i), {48'd0, out_ctrl},
                {48'd0, (tbl[i].ov ? mkc(tbl[i].od) : BUB)});
            chk($sformatf("vec%0d.in_ready", i), {63'd0, in_ready}, {63'd0, tbl[i].ir});
            chk($sformatf("vec%0d.occupancy", i), {62'd0, occupancy}, {62'd0, tbl[i].occ});
        end

        // Asynchronous reset between edges with two entries held.
        step(1, 64'h21, 0, 0);
        step(1, 64'h22, 0, 0);
        chk("async.pre_occ", {62'd0, occupancy}, 64'd2);
        drive(0, '0, 0, 0);
        #2 nRST = 1'b0;
        #1;
        chk_idle("async");
        @(posedge CLK);
        #1;
        chk_idle("async_hold");

        // Stats: one fill, five stalled cycles, drain, three empty cycles, one flushed empty cycle.
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk("stats.rst_stall",  {32'd0, stall_cycles},  64'd0);
        chk("stats.rst_bubble", {32'd0, bubble_cycles}, 64'd0);
        step(1, 64'h31, 0, 0);
        repeat (5) step(0, '0, 0, 0);
        step(0, '0, 1, 0);
        repeat (3) step(0, '0, 1, 0);
        step(0, '0, 1, 1);
        chk("stats.stall_cycles",  {32'd0, stall_cycles},  {32'd0, EXP_STALL});
        chk("stats.bubble_cycles", {32'd0, bubble_cycles}, {32'd0, EXP_BUBBLE});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised elastic pipeline register for the 5-stage datapath. Generalises the fixed-field stage registers into one payload-agnostic block.
- Carries a data payload plus a control field that is forced to a bubble value on flush or empty.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and has no combinational path from out_ready.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- DATA_W, 64: payload width (operands, immediates, PC).
- CTRL_W, 16: control-field width (WEN, dREN, dWEN, halt, aluop, ...).
- CTRL_BUBBLE, '0: control value presented when the stage holds no valid instruction.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream has an entry
- in_ready  out  1  stage can accept; registered
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  output payload
- out_ctrl  out  CTRL_W  output control
- occupancy  out  2  entries held (0..2)
- stall_cycles  out  32  see Optional Feature
- bubble_cycles  out  32  see Optional Feature

Behaviour:
- One clock CLK; reset nRST is asynchronous, active-low.
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. All outputs are driven directly from flops.
- Storage: main slot (drives out_*) and skid slot. State pipe_state_t: PS_EMPTY, PS_ONE, PS_TWO.
- Reset values (async, nRST low): state PS_EMPTY, out_valid 0, in_ready 1, out_data 0, out_ctrl CTRL_BUBBLE, occupancy 0, skid slot 0, counters 0.
- PS_EMPTY:
  - in_fire -> main <= in; go to PS_ONE.
  - Otherwise stay.
- PS_ONE:
  - in_fire & out_fire -> main <= in; stay (full throughput, 1 entry/cycle).
  - out_fire only -> main <= {0, CTRL_BUBBLE}; go to PS_EMPTY.
  - in_fire only -> skid <= in; go to PS_TWO; in_ready drops next cycle.
  - Neither -> hold.
- PS_TWO:
  - in_ready = 0.
  - out_fire -> main <= skid; go to PS_ONE; in_ready rises next cycle.
  - Otherwise hold.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty; strict FIFO order.
- flush (highest priority over all transitions):
  - Next state PS_EMPTY; main <= {0, CTRL_BUBBLE}; skid cleared.
  - An in_fire in the same cycle is discarded. An out_fire in the same cycle still completes downstream.
  - in_ready is 1 the cycle after flush.
- Invariants:
  - out_ctrl == CTRL_BUBBLE whenever out_valid == 0.
  - occupancy == 0/1/2 for PS_EMPTY/PS_ONE/PS_TWO.
  - Never accept while in PS_TWO; never lose an entry on back-pressure.
- Reset mid-operation: all entries dropped immediately; no partial transfer is visible.
- Payload is not transformed; widths pass through unchanged.

Optional Feature:
- Macro PIPE_SKID_REG_STATS_EN.
- Defined:
  - stall_cycles increments each cycle with out_valid & !out_ready.
  - bubble_cycles increments each cycle with !out_valid & !flush.
  - Both are 32-bit, saturate at 32'hFFFF_FFFF, reset to 0, and are unaffected by flush.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Decomposition:
- Package pipe_reg_pkg:
  - pipe_state_t enum (PS_EMPTY, PS_ONE, PS_TWO)
  - localparam STATS_W = 32
  - default width constants for each stage instance
- Sub-module: pipe_sat_ctr (WIDTH param; inc input; saturating counter), instantiated twice under the macro.
- Slot storage and the FSM remain in pipe_skid_reg.

Test Plan:
1. Reset/idle: hold nRST low, then release -> out_valid 0, in_ready 1, out_ctrl == CTRL_BUBBLE, occupancy 0.
2. Streaming: in_valid=1 with payloads 0x1..0x8, out_ready=1 -> outputs 0x1..0x8 on consecutive cycles, 1-cycle latency, occupancy 1 throughout.
3. Back-pressure: stream 0xA, 0xB, 0xC with out_ready=0 ->
   - 0xA in main, 0xB in skid, occupancy 2, in_ready 0, 0xC not accepted.
   - Raise out_ready -> 0xA, 0xB, 0xC emitted in order with no loss.
4. Flush while full (PS_TWO) with in_valid=1 data 0xD -> next cycle out_valid 0, out_ctrl CTRL_BUBBLE, occupancy 0, in_ready 1, and 0xD never appears.
5. Async reset mid-stream: drop nRST between clock edges with occupancy 2 -> outputs return to reset values immediately, without waiting for a clock edge.
6. Stats (macro defined): 5 cycles with out_valid=1 and out_ready=0, then 3 empty cycles -> stall_cycles 5, bubble_cycles ≥3. With the macro undefined, both read 0.
